store_narrow_unit: RTL and testbench

STORE_NARROW_UNIT -- requirements
Module: store_narrow_unit

---
 rtl/store_narrow_unit_pkg.sv | 33 +++
 rtl/store_narrow_unit_if.sv | 30 +++
 rtl/store_narrow_unit_lane_pack.sv | 37 +++
 rtl/store_narrow_unit.sv | 151 +++++++++++++++
 tb/tb_store_narrow_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/store_narrow_unit_pkg.sv
// Shared processor definitions: access size encodings, narrow-store FSM states
// and the alignment rule used by the store and load paths.
package store_narrow_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BEAT_W = 16;
    localparam int unsigned BE_W   = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10,
        RESP = 2'b11
    } state_e;

    // Natural alignment; the reserved size is never legal.
    function automatic logic is_aligned(size_e size, logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return !addr_lo[0];
            SZ_WORD: return addr_lo == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_narrow_unit_if.sv
// Request and 16-bit memory beat channels of the narrow store unit.
// master = requester/memory side, slave = the store unit.
interface store_narrow_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    import store_narrow_unit_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_data;
    logic [1:0]          req_size;

    logic                mem_valid;
    logic                mem_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic [BEAT_W-1:0]   mem_wdata;
    logic [BE_W-1:0]     mem_be;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/store_narrow_unit_lane_pack.sv
// Places store data on the little-endian 16-bit beat lanes and builds the
// byte enables for a given size, address bit 0 and beat index.
module store_lane_pack
    import store_narrow_unit_pkg::*;
(
    input  size_e              size,
    input  logic               addr0,
    input  logic               beat,
    input  logic [DATA_W-1:0]  data,
    output logic [BEAT_W-1:0]  wdata,
    output logic [BE_W-1:0]    be
);

    always_comb begin
        wdata = '0;
        be    = '0;
        case (size)
            SZ_BYTE: begin
                wdata = {data[7:0], data[7:0]};
                be    = addr0 ? 2'b10 : 2'b01;
            end
            SZ_HALF: begin
                wdata = data[15:0];
                be    = 2'b11;
            end
            SZ_WORD: begin
                wdata = beat ? data[31:16] : data[15:0];
                be    = 2'b11;
            end
            default: begin
                wdata = '0;
                be    = '0;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_unit.sv
// Splits byte/half/word stores into one or two halfword memory beats;
// misaligned requests are rejected with an err pulse and no beat.
module store_narrow_unit
    import store_narrow_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    store_narrow_unit_if.slave  bus,
    output logic                done,
    output logic                err
);

    state_e              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                mem_valid_q, mem_valid_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    size_e               size_q, size_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BEAT_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;

    logic                idle;
    logic                accept;
    size_e               req_size_e;
    size_e               lp_size;
    logic                lp_addr0;
    logic [DATA_W-1:0]   lp_data;
    logic [BEAT_W-1:0]   lp_wdata;
    logic [BE_W-1:0]     lp_be;

    assign idle       = (state_q == IDLE);
    assign accept     = bus.req_valid && req_ready_q;
    assign req_size_e = size_e'(bus.req_size);

    // In IDLE the packer sees the incoming request (LO beat); afterwards the
    // captured request with beat=1, which only matters for the word HI beat.
    assign lp_size  = idle ? req_size_e    : size_q;
    assign lp_addr0 = idle ? bus.req_addr[0] : addr_q[0];
    assign lp_data  = idle ? bus.req_data  : data_q;

    store_lane_pack u_lane_pack (
        .size  (lp_size),
        .addr0 (lp_addr0),
        .beat  (!idle),
        .data  (lp_data),
        .wdata (lp_wdata),
        .be    (lp_be)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        mem_valid_d = mem_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        size_d      = size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d      = bus.req_addr;
                    data_d      = bus.req_data;
                    size_d      = req_size_e;
                    req_ready_d = 1'b0;
                    if (is_aligned(req_size_e, bus.req_addr[1:0])) begin
                        state_d     = LO;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {bus.req_addr[ADDR_W-1:1], 1'b0};
                        mem_wdata_d = lp_wdata;
                        mem_be_d    = lp_be;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            LO: begin
                if (bus.mem_ready) begin
                    if (size_q == SZ_WORD) begin
                        // Second beat address wraps modulo 2^ADDR_W.
                        state_d     = HI;
                        mem_addr_d  = {addr_q[ADDR_W-1:1], 1'b0} + ADDR_W'(2);
                        mem_wdata_d = lp_wdata;
                        mem_be_d    = lp_be;
                    end else begin
                        state_d     = RESP;
                        mem_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            HI: begin
                if (bus.mem_ready) begin
                    state_d     = RESP;
                    mem_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            mem_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            mem_valid_q <= mem_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Datapath registers are only meaningful while mem_valid or in flight.
    always_ff @(posedge clk) begin
        addr_q      <= addr_d;
        data_q      <= data_d;
        size_q      <= size_d;
        mem_addr_q  <= mem_addr_d;
        mem_wdata_q <= mem_wdata_d;
        mem_be_q    <= mem_be_d;
    end

    assign bus.req_ready = req_ready_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: vector table of stores with a beat scoreboard,
// plus a hand-written reset-during-HI sequence.
module tb_store_narrow_unit;

    logic clk = 1'b0;
    logic reset;
    logic done;
    logic err;

    always #5 clk = ~clk;

    store_narrow_unit_if #(.ADDR_W(32)) bus ();

    store_narrow_unit #(.ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .done  (done),
        .err   (err)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [15:0] d;
        logic [1:0]  be;
    } beat_t;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        int          stall;
        bit          idle_rdy;
        bit          exp_err;
        int          nbeats;
        beat_t       b0;
        beat_t       b1;
        int          cyc;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    beat_cnt = 0;
    int    done_cnt = 0;
    int    err_cnt = 0;
    beat_t exp_q[$];

    int    stall_n = 0;
    bit    idle_rdy = 1'b0;
    bit    drv_auto = 1'b1;
    int    wait_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Memory-side ready: holds each beat off for stall_n cycles.
    always @(posedge clk) begin
        #1;
        if (drv_auto) begin
            if (bus.mem_valid) begin
                if (wait_cnt >= stall_n) begin
                    bus.mem_ready = 1'b1;
                    wait_cnt = 0;
                end else begin
                    bus.mem_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.mem_ready = idle_rdy;
                wait_cnt = 0;
            end
        end
    end

    // Beat scoreboard, hold-stability and pulse monitor.
    logic        hold_pend = 1'b0;
    beat_t       hold_beat;
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (done || err) check("done_err_exclusive", 64'(done && err), 64'(0));
            if (hold_pend) begin
                check("hold_valid", 64'(bus.mem_valid), 64'(1));
                check("hold_beat", 64'({bus.mem_addr, bus.mem_wdata, bus.mem_be}), 64'(hold_beat));
            end
            if (bus.mem_valid && bus.mem_ready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'({bus.mem_addr, bus.mem_wdata, bus.mem_be}), 64'(0));
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("beat_addr", 64'(bus.mem_addr), 64'(b.a));
                    check("beat_wdata", 64'(bus.mem_wdata), 64'(b.d));
                    check("beat_be", 64'(bus.mem_be), 64'(b.be));
                end
            end
            hold_pend = bus.mem_valid && !bus.mem_ready;
            hold_beat = {bus.mem_addr, bus.mem_wdata, bus.mem_be};
        end else begin
            hold_pend = 1'b0;
        end
    end

    function automatic vec_t mk(input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] data, input int stall, input bit irdy,
                                input bit e, input int nb, input beat_t b0, input beat_t b1,
                                input int cyc);
        vec_t v;
        v.size = size; v.addr = addr; v.data = data; v.stall = stall;
        v.idle_rdy = irdy; v.exp_err = e; v.nbeats = nb; v.b0 = b0; v.b1 = b1; v.cyc = cyc;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int bc0, dc0, ec0, k;
        bit seen;
        @(negedge clk);
        check("req_ready_idle", 64'(bus.req_ready), 64'(1));
        stall_n  = v.stall;
        idle_rdy = v.idle_rdy;
        if (v.nbeats > 0) exp_q.push_back(v.b0);
        if (v.nbeats > 1) exp_q.push_back(v.b1);
        bc0 = beat_cnt; dc0 = done_cnt; ec0 = err_cnt;
        bus.req_addr  = v.addr;
        bus.req_data  = v.data;
        bus.req_size  = v.size;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_data  = $urandom;
        bus.req_size  = 2'($urandom);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 60) begin
            @(negedge clk);
            k++;
            if (done || err) seen = 1'b1;
        end
        check("pulse_seen", 64'(seen), 64'(1));
        check("latency", 64'(k), 64'(v.cyc));
        check("err_pulse", 64'(err), 64'(v.exp_err));
        check("done_pulse", 64'(done), 64'(!v.exp_err));
        @(negedge clk);
        check("pulse_one_cycle", 64'({done, err}), 64'(0));
        check("ready_after", 64'(bus.req_ready), 64'(1));
        check("beat_count", 64'(beat_cnt - bc0), 64'(v.nbeats));
        check("done_count", 64'(done_cnt - dc0), 64'(v.exp_err ? 0 : 1));
        check("err_count", 64'(err_cnt - ec0), 64'(v.exp_err ? 1 : 0));
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    localparam int NV = 12;
    vec_t vecs[NV];
    beat_t nob;

    initial begin
        int bc0, dc0, ec0;
        nob = '0;
        vecs[0]  = mk(2'b00, 32'h0000_1001, 32'h0000_00AB, 0, 0, 0, 1, '{32'h0000_1000, 16'hABAB, 2'b10}, nob, 2);
        vecs[1]  = mk(2'b00, 32'h0000_1002, 32'h1234_56CD, 0, 0, 0, 1, '{32'h0000_1002, 16'hCDCD, 2'b01}, nob, 2);
        vecs[2]  = mk(2'b01, 32'h0000_1004, 32'hFFFF_BEEF, 0, 0, 0, 1, '{32'h0000_1004, 16'hBEEF, 2'b11}, nob, 2);
        vecs[3]  = mk(2'b10, 32'h0000_2000, 32'h1234_5678, 0, 0, 0, 2, '{32'h0000_2000, 16'h5678, 2'b11},
                      '{32'h0000_2002, 16'h1234, 2'b11}, 3);
        vecs[4]  = mk(2'b10, 32'h0000_2000, 32'h1234_5678, 3, 0, 0, 2, '{32'h0000_2000, 16'h5678, 2'b11},
                      '{32'h0000_2002, 16'h1234, 2'b11}, 9);
        vecs[5]  = mk(2'b01, 32'h0000_3001, 32'h0000_1111, 0, 1, 1, 0, nob, nob, 1);
        vecs[6]  = mk(2'b10, 32'h0000_3002, 32'h2222_3333, 0, 1, 1, 0, nob, nob, 1);
        vecs[7]  = mk(2'b11, 32'h0000_3000, 32'h4444_5555, 0, 1, 1, 0, nob, nob, 1);
        vecs[8]  = mk(2'b10, 32'hFFFF_FFFC, 32'hCAFE_F00D, 0, 0, 0, 2, '{32'hFFFF_FFFC, 16'hF00D, 2'b11},
                      '{32'hFFFF_FFFE, 16'hCAFE, 2'b11}, 3);
        vecs[9]  = mk(2'b10, 32'hFFFF_FFFE, 32'h9999_8888, 0, 0, 1, 0, nob, nob, 1);
        vecs[10] = mk(2'b01, 32'h0000_0010, 32'h0000_A55A, 2, 1, 0, 1, '{32'h0000_0010, 16'hA55A, 2'b11}, nob, 4);
        vecs[11] = mk(2'b00, 32'h0000_0007, 32'hFFFF_FF55, 1, 0, 0, 1, '{32'h0000_0006, 16'h5555, 2'b10}, nob, 3);

        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_size  = '0;
        bus.mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_valid", 64'(bus.mem_valid), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_req_ready", 64'(bus.req_ready), 64'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Reset while the HI beat of a word store is stalled.
        drv_auto = 1'b0;
        @(negedge clk);
        exp_q.push_back('{32'h0000_4000, 16'hBEEF, 2'b11});
        bc0 = beat_cnt; dc0 = done_cnt; ec0 = err_cnt;
        bus.req_addr  = 32'h0000_4000;
        bus.req_data  = 32'hDEAD_BEEF;
        bus.req_size  = 2'b10;
        bus.req_valid = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("hi_presented_valid", 64'(bus.mem_valid), 64'(1));
        check("hi_presented_addr", 64'(bus.mem_addr), 64'(32'h0000_4002));
        check("lo_beat_taken", 64'(beat_cnt - bc0), 64'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.req_ready), 64'(1));
        check("post_rst_valid", 64'(bus.mem_valid), 64'(0));
        repeat (8) @(negedge clk);
        check("no_hi_beat", 64'(beat_cnt - bc0), 64'(1));
        check("no_done_after_rst", 64'(done_cnt - dc0), 64'(0));
        check("no_err_after_rst", 64'(err_cnt - ec0), 64'(0));
        check("rst_queue_empty", 64'(exp_q.size()), 64'(0));
        drv_auto = 1'b1;

        // Unit still works after the abandoned store.
        run_vec(vecs[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
